// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, ALU opcodes and sequencer state encoding for the operand stage.
package cpu_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_N  = 8;
  localparam int DEF_ADDR_W = 3;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_NOT   = 3'b101;
  localparam logic [2:0] ALU_SHL   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - general register file: two operand read ports, one debug read port, one write port.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_N  = DEF_REG_N,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [REG_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see the pre-write value during the write cycle.
  assign rdata1   = regs[raddr1];
  assign rdata2   = regs[raddr2];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - four-cycle execute sequencer feeding the 16-bit alu and writing results back.
// Optional immediate B operand selected with ALU_IMM_EN.
module alu_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_N  = DEF_REG_N,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [2:0]        ALU_Code,
  input  logic [DATA_W-1:0] ALU_Out,
  input  logic              Carry,
  input  logic              isZero,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_c,
  output logic              flag_z,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] result_q;
  logic              c_q, z_q;
  logic [DATA_W-1:0] rs1_data, rs2_data, b_sel;
  logic              accept;

  assign accept = in_valid && in_ready;

  cpu_regfile #(
    .DATA_W(DATA_W),
    .REG_N (REG_N),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (state == ST_WB),
    .waddr   (rd_q),
    .wdata   (result_q),
    .raddr1  (rs1_q),
    .raddr2  (rs2_q),
    .dbg_addr(dbg_addr),
    .rdata1  (rs1_data),
    .rdata2  (rs2_data),
    .dbg_data(dbg_data)
  );

`ifdef ALU_IMM_EN
  logic              use_imm_q;
  logic [DATA_W-1:0] imm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      use_imm_q <= 1'b0;
      imm_q     <= '0;
    end else if (state == ST_IDLE && accept) begin
      use_imm_q <= in_use_imm;
      imm_q     <= in_imm;
    end
  end

  assign b_sel = use_imm_q ? imm_q : rs2_data;
`else
  logic unused_imm;
  assign unused_imm = ^{in_use_imm, in_imm};
  assign b_sel      = rs2_data;
`endif

  // Result and destination are held from EXEC until the next instruction's EXEC.
  assign wb_rd   = rd_q;
  assign wb_data = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      in_ready <= 1'b1;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_Code <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      wb_valid <= 1'b0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= in_op;
            rd_q     <= in_rd;
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            in_ready <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          ALU_A    <= rs1_data;
          ALU_B    <= b_sel;
          ALU_Code <= op_q;
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          result_q <= ALU_Out;
          c_q      <= Carry;
          z_q      <= isZero;
          wb_valid <= 1'b1;
          state    <= ST_WB;
        end
        ST_WB: begin
          flag_c   <= c_q;
          flag_z   <= z_q;
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed bench for alu_operand_stage with a behavioural alu and write-back scoreboard.
module tb_alu_operand_stage;
  import cpu_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, in_use_imm;
  logic [2:0]    in_op, ALU_Code;
  logic [AW-1:0] in_rd, in_rs1, in_rs2, wb_rd, dbg_addr;
  logic [DW-1:0] in_imm, ALU_A, ALU_B, ALU_Out, wb_data, dbg_data;
  logic          Carry, isZero, wb_valid, flag_c, flag_z;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Code(ALU_Code),
    .ALU_Out(ALU_Out), .Carry(Carry), .isZero(isZero),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_c(flag_c), .flag_z(flag_z),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural alu: carry is bit DW of the widened result (borrow for SUB).
  logic [DW:0] alu_t;
  always_comb begin
    alu_t = '0;
    case (ALU_Code)
      ALU_ADD: alu_t = {1'b0, ALU_A} + {1'b0, ALU_B};
      ALU_SUB: alu_t = {1'b0, ALU_A} - {1'b0, ALU_B};
      ALU_AND: alu_t = {1'b0, ALU_A & ALU_B};
      ALU_OR:  alu_t = {1'b0, ALU_A | ALU_B};
      ALU_XOR: alu_t = {1'b0, ALU_A ^ ALU_B};
      ALU_NOT: alu_t = {1'b0, ~ALU_A};
      ALU_SHL: alu_t = {ALU_A, 1'b0};
      default: alu_t = {1'b0, ALU_B};
    endcase
    ALU_Out = alu_t[DW-1:0];
    Carry   = alu_t[DW];
    isZero  = (alu_t[DW-1:0] == '0);
  end

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            acc_q[$];
  logic [DW-1:0] model [8];
  int n_checks = 0, n_errors = 0, cyc = 0, wb_cnt = 0, n_pushed = 0;
  int last_acc = 0, prev_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      acc_q.push_back(cyc);
      prev_acc = last_acc;
      last_acc = cyc;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (wb_valid) begin
      exp_t e;
      int   a;
      wb_cnt++;
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        check("wb_unexpected", {31'd0, wb_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("wb_latency", cyc - a, 32'd3);
        check("wb_rd", {29'd0, wb_rd}, {29'd0, e.rd});
        check("wb_data", {16'd0, wb_data}, {16'd0, e.data});
        if (dbg_addr == wb_rd) check("dbg_old_in_wb", {16'd0, dbg_data}, {16'd0, model[wb_rd]});
        model[e.rd] = e.data;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, rs1, rs2,
                       input logic use_imm, input logic [DW-1:0] imm,
                       input logic [DW-1:0] exp_data, input bit expect_wb, input bit hold);
    int n = 0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_use_imm = use_imm; in_imm = imm; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout("accept_wait");
    if (expect_wb) begin
      exp_q.push_back('{rd: rd, data: exp_data});
      n_pushed++;
    end
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    if (n >= 20) timeout("idle_wait");
  endtask

  task automatic check_reg(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    dbg_addr = a;
    #1;
    check(tag, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  initial begin
    int wb_before;
    logic [DW-1:0] exp_b;
    in_valid = 0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_use_imm = 0; in_imm = '0; dbg_addr = '0;
    for (int i = 0; i < 8; i++) model[i] = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_flag_c", {31'd0, flag_c}, 32'd0);
    check("rst_flag_z", {31'd0, flag_z}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_alu_a", {16'd0, ALU_A}, 32'd0);
    check("rst_alu_b", {16'd0, ALU_B}, 32'd0);
    check("rst_alu_code", {29'd0, ALU_Code}, 32'd0);
    for (int i = 0; i < 8; i++) check_reg("rst_dbg", AW'(i), 16'h0000);
    dbg_addr = '0;
    @(negedge clk);

    // Build constants from the all-zero register file: r7=FFFF, r6=1, r1=2, r2=5.
    issue(ALU_NOT, 3'd7, 3'd0, 3'd0, 1'b0, '0, 16'hFFFF, 1, 0); wait_idle();
    issue(ALU_SUB, 3'd6, 3'd0, 3'd7, 1'b0, '0, 16'h0001, 1, 0); wait_idle();
    issue(ALU_ADD, 3'd1, 3'd6, 3'd6, 1'b0, '0, 16'h0002, 1, 0); wait_idle();
    issue(ALU_ADD, 3'd2, 3'd1, 3'd1, 1'b0, '0, 16'h0004, 1, 0); wait_idle();
    issue(ALU_ADD, 3'd2, 3'd2, 3'd6, 1'b0, '0, 16'h0005, 1, 0); wait_idle();

    dbg_addr = 3'd3;
    issue(3'b001, 3'd3, 3'd1, 3'd2, 1'b0, '0, 16'hFFFD, 1, 0); wait_idle();
    check_reg("r3_after_sub", 3'd3, 16'hFFFD);
    check("sub_alu_a", {16'd0, ALU_A}, 32'h0002);
    check("sub_alu_b", {16'd0, ALU_B}, 32'h0005);
    check("sub_alu_code", {29'd0, ALU_Code}, 32'd1);
    check("sub_flag_c", {31'd0, flag_c}, 32'd1);
    check("sub_flag_z", {31'd0, flag_z}, 32'd0);
    @(negedge clk);

    issue(ALU_ADD, 3'd4, 3'd1, 3'd2, 1'b0, '0, 16'h0007, 1, 1);
    issue(ALU_ADD, 3'd5, 3'd4, 3'd4, 1'b0, '0, 16'h000E, 1, 0);
    wait_idle();
    check("b2b_spacing", last_acc - prev_acc, 32'd4);
    check_reg("b2b_r4", 3'd4, 16'h0007);
    check_reg("b2b_r5", 3'd5, 16'h000E);
    dbg_addr = '0;
    @(negedge clk);

    issue(ALU_ADD, 3'd1, 3'd7, 3'd0, 1'b0, '0, 16'hFFFF, 1, 0); wait_idle();
    issue(ALU_ADD, 3'd2, 3'd6, 3'd0, 1'b0, '0, 16'h0001, 1, 0); wait_idle();
    issue(ALU_ADD, 3'd0, 3'd1, 3'd2, 1'b0, '0, 16'h0000, 1, 0); wait_idle();
    check("carry_flag_c", {31'd0, flag_c}, 32'd1);
    check("carry_flag_z", {31'd0, flag_z}, 32'd1);
    issue(ALU_OR, 3'd0, 3'd2, 3'd2, 1'b0, '0, 16'h0001, 1, 0); wait_idle();
    check("nz_flag_c", {31'd0, flag_c}, 32'd0);
    check("nz_flag_z", {31'd0, flag_z}, 32'd0);
    check_reg("r0_written", 3'd0, 16'h0001);
    dbg_addr = '0;
    @(negedge clk);

`ifdef ALU_IMM_EN
    exp_b = 16'h0007;
`else
    exp_b = 16'h000E;
`endif
    issue(ALU_PASSB, 3'd3, 3'd1, 3'd5, 1'b1, 16'h0007, exp_b, 1, 0);
    @(negedge clk);
    check("imm_alu_b_exec", {16'd0, ALU_B}, {16'd0, exp_b});
    wait_idle();
    check_reg("imm_r3", 3'd3, exp_b);
    dbg_addr = '0;
    @(negedge clk);

    wb_before = wb_cnt;
    issue(ALU_OR, 3'd6, 3'd1, 3'd2, 1'b0, '0, 16'hFFFF, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acc_q.delete();
    for (int i = 0; i < 8; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    check("abort_no_wb", wb_cnt - wb_before, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_flag_c", {31'd0, flag_c}, 32'd0);
    check("abort_flag_z", {31'd0, flag_z}, 32'd0);
    check_reg("abort_r6", 3'd6, 16'h0000);
    check_reg("abort_r1", 3'd1, 16'h0000);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("wb_total", wb_cnt, n_pushed);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
